// File: rtl/cx_dma_burst_sched.sv
// cx_dma_burst_sched: per-CXU DMA descriptor sequencer. Splits one descriptor
// into INCR bursts capped at MAX_BEATS beats and never crossing a 4 KB page,
// throttles in-flight bursts and emits one done token per descriptor.
module cx_dma_burst_sched #(
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_BEATS       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_WIDTH        = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  s_desc_valid,
  output logic                  s_desc_ready,
  input  logic [ADDR_WIDTH-1:0] s_desc_base,
  input  logic [ADDR_WIDTH-1:0] s_desc_end,
  input  logic [2:0]            s_desc_size,
  input  logic [ID_WIDTH-1:0]   s_desc_id,
  output logic                  m_req_valid,
  input  logic                  m_req_ready,
  output logic [ADDR_WIDTH-1:0] m_req_base,
  output logic [ADDR_WIDTH-1:0] m_req_end,
  output logic [2:0]            m_req_size,
  output logic [ID_WIDTH-1:0]   m_req_id,
  input  logic                  i_cpl,
  output logic                  m_done_valid,
  input  logic                  m_done_ready,
  output logic [ID_WIDTH-1:0]   m_done_id,
  output logic                  o_busy
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  // One extra bit so end = all-ones yields remaining = 2^ADDR_WIDTH without wrap.
  localparam int XW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] cur_q;
  logic [ADDR_WIDTH-1:0] end_q;
  logic [2:0]            size_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [OW-1:0]         outstanding;
  logic [OW-1:0]         outstanding_nxt;

  logic [XW-1:0]         cur_x;
  logic [XW-1:0]         end_x;
  logic [XW-1:0]         remaining;
  logic [XW-1:0]         to_4k;
  logic [XW-1:0]         cap;
  logic [XW-1:0]         burst;
  logic [XW-1:0]         req_end_x;
  logic                  last_burst;
  logic                  desc_hs;
  logic                  req_hs;
  logic                  cpl_ok;
  logic [ADDR_WIDTH-1:0] size_mask;

  assign desc_hs = s_desc_valid && s_desc_ready;
  assign req_hs  = m_req_valid && m_req_ready;
  // A completion with nothing in flight is a system error; it must not underflow.
  assign cpl_ok  = i_cpl && (outstanding != '0);

  // Burst length = min(bytes left, bytes to the 4 KB page end, beat cap), from registers only.
  always_comb begin
    cur_x     = {1'b0, cur_q};
    end_x     = {1'b0, end_q};
    remaining = end_x - cur_x + XW'(1);
    to_4k     = XW'(13'd4096 - {1'b0, cur_q[11:0]});
    cap       = XW'(MAX_BEATS) << size_q;
    burst     = remaining;
    if (to_4k < burst) burst = to_4k;
    if (cap < burst)   burst = cap;
    req_end_x  = cur_x + burst - XW'(1);
    last_burst = (req_end_x == end_x);
  end

  // In-flight burst count: +1 per issued request, -1 per completion, net zero when both.
  always_comb begin
    outstanding_nxt = outstanding;
    case ({req_hs, cpl_ok})
      2'b10:   outstanding_nxt = outstanding + OW'(1);
      2'b01:   outstanding_nxt = outstanding - OW'(1);
      default: outstanding_nxt = outstanding;
    endcase
  end

  // State register and outstanding counter.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) begin
      state       <= S_IDLE;
      outstanding <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
    state_nxt    = state;
    s_desc_ready = 1'b0;
    m_req_valid  = 1'b0;
    m_done_valid = 1'b0;
    o_busy       = 1'b1;
    case (state)
      S_IDLE: begin
        s_desc_ready = 1'b1;
        o_busy       = 1'b0;
        if (s_desc_valid) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        m_req_valid = (outstanding < OW'(MAX_OUTSTANDING));
        if (m_req_valid && m_req_ready && last_burst) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (outstanding_nxt == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        m_done_valid = 1'b1;
        if (m_done_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request and done fields are driven only while their phase is active, zero otherwise.
  always_comb begin
    m_req_base = '0;
    m_req_end  = '0;
    m_req_size = '0;
    m_req_id   = '0;
    m_done_id  = '0;
    if (state == S_ISSUE) begin
      m_req_base = cur_q;
      m_req_end  = req_end_x[ADDR_WIDTH-1:0];
      m_req_size = size_q;
      m_req_id   = id_q;
    end
    if (state == S_DONE) m_done_id = id_q;
  end

  // Descriptor registers: latched on accept, cursor advanced past each issued burst.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cur_q  <= '0;
      end_q  <= '0;
      size_q <= '0;
      id_q   <= '0;
    end else if (desc_hs) begin
      cur_q  <= s_desc_base;
      end_q  <= s_desc_end;
      size_q <= s_desc_size;
      id_q   <= s_desc_id;
    end else if (req_hs) begin
      cur_q  <= req_end_x[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
    end
  end

  assign size_mask = (ADDR_WIDTH'(1) << s_desc_size) - ADDR_WIDTH'(1);

  // Protocol checks: stray completions and misaligned descriptors.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      a_no_stray_cpl: assert (!(i_cpl && (outstanding == '0)));
      if (desc_hs) begin
        a_base_aligned: assert ((s_desc_base & size_mask) == '0);
        a_end_aligned:  assert (((s_desc_end + ADDR_WIDTH'(1)) & size_mask) == '0);
      end
    end
  end

endmodule

// File: tb/tb_cx_dma_burst_sched.sv
// Testbench for cx_dma_burst_sched: scenario tasks plus a request/done scoreboard.
module tb_cx_dma_burst_sched;

  localparam int AW = 32;
  localparam int IW = 4;
  localparam int MB = 16;
  localparam int MO = 2;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          s_desc_valid;
  logic          s_desc_ready;
  logic [AW-1:0] s_desc_base;
  logic [AW-1:0] s_desc_end;
  logic [2:0]    s_desc_size;
  logic [IW-1:0] s_desc_id;
  logic          m_req_valid;
  logic          m_req_ready;
  logic [AW-1:0] m_req_base;
  logic [AW-1:0] m_req_end;
  logic [2:0]    m_req_size;
  logic [IW-1:0] m_req_id;
  logic          i_cpl;
  logic          m_done_valid;
  logic          m_done_ready;
  logic [IW-1:0] m_done_id;
  logic          o_busy;

  cx_dma_burst_sched #(
    .ADDR_WIDTH(AW), .MAX_BEATS(MB), .MAX_OUTSTANDING(MO), .ID_WIDTH(IW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .s_desc_valid(s_desc_valid), .s_desc_ready(s_desc_ready),
    .s_desc_base(s_desc_base), .s_desc_end(s_desc_end),
    .s_desc_size(s_desc_size), .s_desc_id(s_desc_id),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_base(m_req_base), .m_req_end(m_req_end),
    .m_req_size(m_req_size), .m_req_id(m_req_id),
    .i_cpl(i_cpl),
    .m_done_valid(m_done_valid), .m_done_ready(m_done_ready),
    .m_done_id(m_done_id), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] last;
    logic [2:0]    size;
    logic [IW-1:0] id;
  } req_t;

  req_t          req_q[$];
  logic [IW-1:0] done_q[$];
  req_t          exp_r;
  logic [IW-1:0] exp_id;
  int            total = 0;
  int            bad = 0;
  int            hs_count = 0;
  int            cpl_given = 0;

  // Scoreboard: compare every request and done handshake against queued expectations.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (m_req_valid && m_req_ready) begin
        hs_count++;
        total++;
        if (req_q.size() == 0) begin
          bad++;
          $display("FAIL req_unexpected: got base=%h end=%h, expected no request", m_req_base, m_req_end);
        end else begin
          exp_r = req_q.pop_front();
          if (m_req_base !== exp_r.base || m_req_end !== exp_r.last ||
              m_req_size !== exp_r.size || m_req_id !== exp_r.id) begin
            bad++;
            $display("FAIL req_fields: got %h..%h size=%0d id=%h, want %h..%h size=%0d id=%h",
                     m_req_base, m_req_end, m_req_size, m_req_id,
                     exp_r.base, exp_r.last, exp_r.size, exp_r.id);
          end
        end
      end
      if (m_done_valid && m_done_ready) begin
        total++;
        if (done_q.size() == 0) begin
          bad++;
          $display("FAIL done_unexpected: got id=%h, expected no done", m_done_id);
        end else begin
          exp_id = done_q.pop_front();
          if (m_done_id !== exp_id) begin
            bad++;
            $display("FAIL done_id: got %h want %h", m_done_id, exp_id);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Reference split: walk the range, ending each burst at the nearest of
  // descriptor end, beat cap, or last byte of the current 4 KB page.
  task automatic model_push(input logic [AW-1:0] base, input logic [AW-1:0] last,
                            input logic [2:0] size, input logic [IW-1:0] id);
    longint unsigned cur, e, cap_end, page_end;
    req_t r;
    cur = base;
    while (cur <= last) begin
      cap_end  = cur + (longint'(MB) << size) - 1;
      page_end = cur | 64'hFFF;
      e = last;
      if (cap_end < e)  e = cap_end;
      if (page_end < e) e = page_end;
      r.base = cur[AW-1:0];
      r.last = e[AW-1:0];
      r.size = size;
      r.id   = id;
      req_q.push_back(r);
      cur = e + 1;
    end
    done_q.push_back(id);
  endtask

  task automatic send_desc(input logic [AW-1:0] base, input logic [AW-1:0] last,
                           input logic [2:0] size, input logic [IW-1:0] id);
    bit ok = 1'b0;
    int n = 0;
    model_push(base, last, size, id);
    s_desc_valid = 1'b1;
    s_desc_base  = base;
    s_desc_end   = last;
    s_desc_size  = size;
    s_desc_id    = id;
    while (n < 20 && !ok) begin
      @(negedge i_clk);
      ok = s_desc_ready;
      step();
      n++;
    end
    s_desc_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL desc_accept: ready=%b after %0d cycles, want 1", s_desc_ready, n);
    end
  endtask

  // Feed one completion per cycle while bursts are in flight until done appears.
  task automatic run_to_done();
    bit seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      if (hs_count - cpl_given > 0) begin
        i_cpl = 1'b1;
        cpl_given++;
      end else begin
        i_cpl = 1'b0;
      end
      @(negedge i_clk);
      if (m_done_valid) seen = 1'b1;
      else step();
    end
    i_cpl = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL done_timeout: done_valid=%b, want 1 within 300 cycles", m_done_valid);
    end
    step();
  endtask

  task automatic consume_done();
    m_done_ready = 1'b1;
    step();
    m_done_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    s_desc_valid = 1'b0; s_desc_base = '0; s_desc_end = '0; s_desc_size = '0; s_desc_id = '0;
    m_req_ready = 1'b0; i_cpl = 1'b0; m_done_ready = 1'b0;
    repeat (3) step();
    i_rst = 1'b0;
    @(negedge i_clk);
    total++; if (s_desc_ready !== 1'b1) begin bad++; $display("FAIL reset_desc_ready: got %b want 1", s_desc_ready); end
    total++; if (m_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", m_req_valid); end
    total++; if (m_done_valid !== 1'b0) begin bad++; $display("FAIL reset_done_valid: got %b want 0", m_done_valid); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    total++; if (m_req_base !== '0 || m_req_end !== '0 || m_done_id !== '0) begin
      bad++; $display("FAIL reset_data: base=%h end=%h done_id=%h want 0", m_req_base, m_req_end, m_done_id);
    end
    step();
  endtask

  task automatic test_single();
    m_req_ready = 1'b1;
    send_desc(32'h1000, 32'h103F, 3'd2, 4'h3);
    @(negedge i_clk);
    total++; if (m_req_valid !== 1'b1 || o_busy !== 1'b1) begin
      bad++; $display("FAIL single_req_latency: valid=%b busy=%b want 1 1", m_req_valid, o_busy);
    end
    step();
    @(negedge i_clk);
    total++; if (m_req_valid !== 1'b0 || m_done_valid !== 1'b0) begin
      bad++; $display("FAIL single_drain: req_valid=%b done_valid=%b want 0 0", m_req_valid, m_done_valid);
    end
    step();
    i_cpl = 1'b1; cpl_given++;
    step();
    i_cpl = 1'b0;
    @(negedge i_clk);
    total++; if (m_done_valid !== 1'b1 || m_done_id !== 4'h3) begin
      bad++; $display("FAIL single_done_latency: valid=%b id=%h want 1 3", m_done_valid, m_done_id);
    end
    step();
    consume_done();
  endtask

  task automatic test_back_to_back();
    int start = hs_count;
    m_req_ready = 1'b1;
    send_desc(32'h1000, 32'h10FF, 3'd2, 4'h5);
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      total++; if (m_req_valid !== 1'b1) begin
        bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, m_req_valid);
      end
      step();
      if (i == 0) i_cpl = 1'b1;
    end
    @(negedge i_clk);
    total++; if (m_req_valid !== 1'b0 || m_done_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_before_last_cpl: req_valid=%b done_valid=%b want 0 0", m_req_valid, m_done_valid);
    end
    total++; if (hs_count - start != 4) begin
      bad++; $display("FAIL b2b_count: got %0d requests want 4", hs_count - start);
    end
    step();
    i_cpl = 1'b0;
    cpl_given += 4;
    @(negedge i_clk);
    total++; if (m_done_valid !== 1'b1 || m_done_id !== 4'h5) begin
      bad++; $display("FAIL b2b_done: valid=%b id=%h want 1 5", m_done_valid, m_done_id);
    end
    step();
    consume_done();
    @(negedge i_clk);
    total++; if (s_desc_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle_ready: got %b want 1", s_desc_ready); end
    step();
  endtask

  task automatic test_4k_split();
    m_req_ready = 1'b0;
    send_desc(32'h0FF0, 32'h100F, 3'd3, 4'h9);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      total++; if (m_req_valid !== 1'b1 || m_req_base !== 32'h0FF0 || m_req_end !== 32'h0FFF) begin
        bad++; $display("FAIL 4k_stall_stable[%0d]: valid=%b %h..%h want 1 0ff0..0fff", i, m_req_valid, m_req_base, m_req_end);
      end
      step();
    end
    m_req_ready = 1'b1;
    run_to_done();
    consume_done();
  endtask

  task automatic test_outstanding_limit();
    int start = hs_count;
    m_req_ready = 1'b1;
    send_desc(32'h2000, 32'h20FF, 3'd2, 4'hA);
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      total++; if (m_req_valid !== 1'b1) begin bad++; $display("FAIL limit_issue[%0d]: got %b want 1", i, m_req_valid); end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      total++; if (m_req_valid !== 1'b0) begin bad++; $display("FAIL limit_block[%0d]: got %b want 0", i, m_req_valid); end
      step();
    end
    total++; if (hs_count - start != 2) begin bad++; $display("FAIL limit_count: got %0d want 2", hs_count - start); end
    i_cpl = 1'b1; cpl_given++;
    step();
    i_cpl = 1'b0;
    @(negedge i_clk);
    total++; if (m_req_valid !== 1'b1) begin bad++; $display("FAIL limit_resume: got %b want 1", m_req_valid); end
    step();
    total++; if (hs_count - start != 3) begin bad++; $display("FAIL limit_third: got %0d want 3", hs_count - start); end
    run_to_done();
    consume_done();
  endtask

  task automatic test_done_hold();
    m_req_ready = 1'b1;
    send_desc(32'h3000, 32'h3003, 3'd2, 4'h6);
    run_to_done();
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      total++; if (m_done_valid !== 1'b1 || m_done_id !== 4'h6 || s_desc_ready !== 1'b0) begin
        bad++; $display("FAIL done_hold[%0d]: valid=%b id=%h desc_ready=%b want 1 6 0", i, m_done_valid, m_done_id, s_desc_ready);
      end
      step();
    end
    consume_done();
  endtask

  task automatic test_reset_mid();
    m_req_ready = 1'b1;
    send_desc(32'h4000, 32'h40FF, 3'd2, 4'hB);
    step();
    step();
    @(negedge i_clk);
    total++; if (m_req_valid !== 1'b0 || o_busy !== 1'b1) begin
      bad++; $display("FAIL rstmid_stall: req_valid=%b busy=%b want 0 1", m_req_valid, o_busy);
    end
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    req_q.delete();
    done_q.delete();
    cpl_given = hs_count;
    @(negedge i_clk);
    total++; if (m_req_valid !== 1'b0 || m_done_valid !== 1'b0 || o_busy !== 1'b0 || s_desc_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_state: req=%b done=%b busy=%b ready=%b want 0 0 0 1",
                      m_req_valid, m_done_valid, o_busy, s_desc_ready);
    end
    step();
    send_desc(32'h5000, 32'h507F, 3'd2, 4'hC);
    run_to_done();
    consume_done();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_4k_split();
    test_outstanding_limit();
    test_done_hold();
    test_reset_mid();
    total++;
    if (req_q.size() != 0 || done_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: %0d requests %0d dones still expected, want 0 0", req_q.size(), done_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
